ste_thr_det: RTL and testbench
==============================

// Module: ste_thr_det
// PURPOSE
// - Threshold detector with hysteresis and debounce; sits directly downstream of the
//   IIR averaging stage and consumes its averaged sample + update strobe.
// - Produces a debounced level flag plus one-cycle rise/fall event pulses for the
//   control/IRQ logic. Counts only on strobed samples; idle cycles are ignored.
// PARAMETERS
// - DATA_W  16  width of averaged sample and thresholds (unsigned)
// - DEB_W    4  width of debounce count; max 2**DEB_W consecutive samples
// PORTS
// - clk          in   1       system clock
// - rst          in   1       asynchronous reset, active high
// - din_i        in   DATA_W  averaged sample (unsigned)
// - din_vld_i    in   1       sample valid strobe (from averager update output)
// - thr_hi_i     in   DATA_W  assert threshold (sample >= thr_hi qualifies high)
// - thr_lo_i     in   DATA_W  deassert threshold (sample <= thr_lo qualifies low)
// - deb_i        in   DEB_W   debounce: transition on (deb_i+1)-th consecutive qualifying sample
// - det_en_i     in   1       detector enable
// - det_clr_i    in   1       synchronous clear of state, counter, peak
// - det_o        out  1       debounced detect level
// - det_rise_o   out  1       1-cycle pulse on det_o 0->1
// - det_fall_o   out  1       1-cycle pulse on det_o 1->0
// - err_cfg_o    out  1       registered: thr_lo_i > thr_hi_i
// - peak_o       out  DATA_W  peak-hold value (see CONFIGURATION)
// BEHAVIOUR
// - Clock clk; one clock domain; reset asynchronous, active high. All outputs registered, reset to 0; FSM to IDLE, cnt to 0.
// - Priority per cycle: rst > det_clr_i > !det_en_i > err_cfg > sample processing.
// - FSM: IDLE, LOW, PEND_HI, HIGH, PEND_LO. cnt is DEB_W bits, unsigned.
//   IDLE: det_o=0, no pulses; det_en_i=1 -> LOW next clk.
//   LOW: vld & din>=thr_hi: deb_i==0 -> HIGH (rise) else PEND_HI, cnt=1.
//   PEND_HI: vld & din>=thr_hi: cnt==deb_i -> HIGH (rise), cnt=0; else cnt+1.
//            vld & din<thr_hi -> LOW, cnt=0 (debounce restarts).
//   HIGH / PEND_LO: mirror of LOW / PEND_HI using din<=thr_lo, target LOW, fall pulse.
//            PEND_LO & vld & din>thr_lo -> HIGH, cnt=0.
//   !din_vld_i: state and cnt hold.
// - Latency: det_o and pulse change on the clk edge that accepts the qualifying
//   sample (visible 1 clk after strobe). Pulses exactly 1 clk wide.
// - Hysteresis band thr_lo<din<thr_hi: never qualifies; equality qualifies both ends.
// - cnt never wraps: deb_i max 2**DEB_W-1 bounds it. deb_i changed mid-pend:
//   compare uses current deb_i; cnt>deb_i on qualifying sample -> transition.
// - err_cfg (thr_lo_i>thr_hi_i): err_cfg_o=1 next clk; cnt cleared, state and
//   det_o frozen, no pulses until config valid again (then continues from frozen state).
// - det_clr_i: state -> LOW if enabled else IDLE, det_o=0, cnt=0, no fall pulse,
//   coincident sample discarded.
// - det_en_i=0 mid-operation: -> IDLE, det_o=0, no fall pulse.
// - rst mid-operation: immediate async return to reset values.
// CONFIGURATION
// - Macro STE_THR_DET_PEAK_EN defined: peak_o = max valid din_i accepted since
//   reset/clr/enable-rise (reset to 0 on each); updated on same edge as FSM;
//   tracks regardless of FSM state except IDLE and err_cfg freeze.
// - Not defined: peak_o tied to 0, no peak register synthesised; port list unchanged.
// TESTING
// - rst=1 with random inputs -> all outputs 0; release + det_en_i=1 -> LOW, det_o=0.
// - thr_hi=1000, thr_lo=800, deb_i=2; strobes 1000,1000,1000 -> det_rise_o 1 clk
//   after 3rd strobe, det_o=1; non-strobe cycles between samples do not count.
// - same cfg, strobes 1000,1000,900,1000,1000,1000 -> no rise until 6th strobe.
// - in HIGH, strobes 801,800,800,800 -> 801 ignored; det_fall_o after 4th, det_o=0.
// - thr_lo=1200, thr_hi=1000 -> err_cfg_o=1 next clk; strobes of 2000 cause no
//   transition; restore thr_lo=800 -> err_cfg_o=0, debounce resumes from cnt=0.
// - HIGH, det_clr_i=1 with coincident strobe 0x0FFF -> det_o=0, no fall pulse;
//   with STE_THR_DET_PEAK_EN strobes 0x0100,0x0FFF,0x0200 -> peak_o=0x0FFF.

Source files
------------

// File: rtl/ste_thr_det.sv
// ste_thr_det: threshold detector with hysteresis and debounce.
// Consumes the averaged sample and its update strobe. Produces a debounced
// level flag plus one-cycle rise/fall pulses. Only strobed samples count
// toward the debounce; idle cycles leave state and count untouched.
// Optional feature macro: STE_THR_DET_PEAK_EN enables the peak-hold register
// on peak_o. Without it, peak_o is tied to zero.
module ste_thr_det #(
    parameter int DATA_W = 16,
    parameter int DEB_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din_i,
    input  logic              din_vld_i,
    input  logic [DATA_W-1:0] thr_hi_i,
    input  logic [DATA_W-1:0] thr_lo_i,
    input  logic [DEB_W-1:0]  deb_i,
    input  logic              det_en_i,
    input  logic              det_clr_i,
    output logic              det_o,
    output logic              det_rise_o,
    output logic              det_fall_o,
    output logic              err_cfg_o,
    output logic [DATA_W-1:0] peak_o
);

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        PEND_HI,
        HIGH,
        PEND_LO
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DEB_W-1:0]  cnt;
    logic [DEB_W-1:0]  cnt_nxt;
    logic              det_nxt;
    logic              rise_nxt;
    logic              fall_nxt;
    logic              cfg_err;
    logic              q_hi;
    logic              q_lo;

    // An inverted threshold pair makes the hysteresis band meaningless, so the
    // detector freezes while it lasts. Equality qualifies at both ends.
    assign cfg_err = (thr_lo_i > thr_hi_i);
    assign q_hi    = (din_i >= thr_hi_i);
    assign q_lo    = (din_i <= thr_lo_i);

    // State, debounce count and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            det_o      <= 1'b0;
            det_rise_o <= 1'b0;
            det_fall_o <= 1'b0;
            err_cfg_o  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            det_o      <= det_nxt;
            det_rise_o <= rise_nxt;
            det_fall_o <= fall_nxt;
            err_cfg_o  <= cfg_err;
        end
    end

    // Next-state logic. Priority is clear, then disable, then config error,
    // then sample processing. The count compare uses >= so that lowering
    // deb_i mid-debounce still lets the next qualifying sample transition.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        det_nxt   = det_o;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (det_clr_i) begin
            state_nxt = det_en_i ? LOW : IDLE;
            cnt_nxt   = '0;
            det_nxt   = 1'b0;
        end else if (!det_en_i) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            det_nxt   = 1'b0;
        end else if (cfg_err) begin
            cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                    det_nxt   = 1'b0;
                end
                LOW: begin
                    if (din_vld_i && q_hi) begin
                        if (deb_i == '0) begin
                            state_nxt = HIGH;
                            det_nxt   = 1'b1;
                            rise_nxt  = 1'b1;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = PEND_HI;
                            cnt_nxt   = DEB_W'(1);
                        end
                    end
                end
                PEND_HI: begin
                    if (din_vld_i) begin
                        if (q_hi) begin
                            if (cnt >= deb_i) begin
                                state_nxt = HIGH;
                                det_nxt   = 1'b1;
                                rise_nxt  = 1'b1;
                                cnt_nxt   = '0;
                            end else begin
                                cnt_nxt = cnt + DEB_W'(1);
                            end
                        end else begin
                            state_nxt = LOW;
                            cnt_nxt   = '0;
                        end
                    end
                end
                HIGH: begin
                    if (din_vld_i && q_lo) begin
                        if (deb_i == '0) begin
                            state_nxt = LOW;
                            det_nxt   = 1'b0;
                            fall_nxt  = 1'b1;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = PEND_LO;
                            cnt_nxt   = DEB_W'(1);
                        end
                    end
                end
                PEND_LO: begin
                    if (din_vld_i) begin
                        if (q_lo) begin
                            if (cnt >= deb_i) begin
                                state_nxt = LOW;
                                det_nxt   = 1'b0;
                                fall_nxt  = 1'b1;
                                cnt_nxt   = '0;
                            end else begin
                                cnt_nxt = cnt + DEB_W'(1);
                            end
                        end else begin
                            state_nxt = HIGH;
                            cnt_nxt   = '0;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    det_nxt   = 1'b0;
                end
            endcase
        end
    end

`ifdef STE_THR_DET_PEAK_EN
    logic en_q;

    // Peak hold: cleared on clear and on enable rise, held while disabled,
    // IDLE or config error, otherwise tracks the largest strobed sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_o <= '0;
            en_q   <= 1'b0;
        end else begin
            en_q <= det_en_i;
            if (det_clr_i || (det_en_i && !en_q)) begin
                peak_o <= '0;
            end else if (det_en_i && !cfg_err && (state != IDLE) &&
                         din_vld_i && (din_i > peak_o)) begin
                peak_o <= din_i;
            end
        end
    end
`else
    assign peak_o = '0;
`endif

endmodule

// File: tb/tb_ste_thr_det.sv
// tb_ste_thr_det: directed plus randomized checks of ste_thr_det against a
// run-length reference model of the debounced hysteresis detector.
module tb_ste_thr_det;

    logic        clk;
    logic        rst;
    logic [15:0] din_i;
    logic        din_vld_i;
    logic [15:0] thr_hi_i;
    logic [15:0] thr_lo_i;
    logic [3:0]  deb_i;
    logic        det_en_i;
    logic        det_clr_i;
    logic        det_o;
    logic        det_rise_o;
    logic        det_fall_o;
    logic        err_cfg_o;
    logic [15:0] peak_o;

    int checks = 0;
    int errors = 0;

    // Reference model: level, length of the current run of qualifying samples
    bit          m_active;
    bit          m_level;
    int          m_run;
    bit          m_rise;
    bit          m_fall;
    bit          m_err;
    bit          m_en_prev;
    logic [15:0] m_peak;

    ste_thr_det #(.DATA_W(16), .DEB_W(4)) dut (
        .clk(clk), .rst(rst), .din_i(din_i), .din_vld_i(din_vld_i),
        .thr_hi_i(thr_hi_i), .thr_lo_i(thr_lo_i), .deb_i(deb_i),
        .det_en_i(det_en_i), .det_clr_i(det_clr_i), .det_o(det_o),
        .det_rise_o(det_rise_o), .det_fall_o(det_fall_o),
        .err_cfg_o(err_cfg_o), .peak_o(peak_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        m_active = 0; m_level = 0; m_run = 0; m_rise = 0; m_fall = 0;
        m_err = 0; m_en_prev = 0; m_peak = '0;
    endtask

    // Advance the model by one clock using the inputs that were applied at the edge
    task automatic modelStep();
        bit q;
        m_rise = 0;
        m_fall = 0;
        m_err  = (thr_lo_i > thr_hi_i);
        if (det_clr_i) begin
            m_active = det_en_i; m_level = 0; m_run = 0; m_peak = '0;
        end else begin
            if (det_en_i && !m_en_prev) m_peak = '0;
            if (!det_en_i) begin
                m_active = 0; m_level = 0; m_run = 0;
            end else if (thr_lo_i > thr_hi_i) begin
                m_run = 0;
            end else if (!m_active) begin
                m_active = 1; m_run = 0;
            end else if (din_vld_i) begin
                if (din_i > m_peak) m_peak = din_i;
                q = m_level ? (din_i <= thr_lo_i) : (din_i >= thr_hi_i);
                if (q) begin
                    m_run++;
                    if (m_run > int'(deb_i)) begin
                        m_level = !m_level;
                        m_rise  = m_level;
                        m_fall  = !m_level;
                        m_run   = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
        end
        m_en_prev = det_en_i;
    endtask

    task automatic checkOutput();
        chk("det_o", {15'b0, det_o}, {15'b0, m_level});
        chk("det_rise_o", {15'b0, det_rise_o}, {15'b0, m_rise});
        chk("det_fall_o", {15'b0, det_fall_o}, {15'b0, m_fall});
        chk("err_cfg_o", {15'b0, err_cfg_o}, {15'b0, m_err});
`ifdef STE_THR_DET_PEAK_EN
        chk("peak_o", peak_o, m_peak);
`else
        chk("peak_o", peak_o, 16'h0000);
`endif
    endtask

    // Apply one clock of stimulus, then check #1 after the edge
    task automatic applyStimulus(input logic vld, input logic [15:0] din);
        din_vld_i = vld;
        din_i     = din;
        @(posedge clk);
        #1;
        modelStep();
        checkOutput();
    endtask

    task automatic strobe(input logic [15:0] din);
        applyStimulus(1'b1, din);
        applyStimulus(1'b0, 16'h0000);
    endtask

    initial begin
        rst = 1'b1; din_i = '0; din_vld_i = 0; thr_hi_i = '0; thr_lo_i = '0;
        deb_i = '0; det_en_i = 0; det_clr_i = 0;
        modelReset();

        $display("[TB] reset with random inputs");
        for (int i = 0; i < 4; i++) begin
            din_i = 16'($urandom); din_vld_i = 1'($urandom); thr_hi_i = 16'($urandom);
            thr_lo_i = 16'($urandom); deb_i = 4'($urandom); det_en_i = 1'($urandom);
            det_clr_i = 1'($urandom);
            @(posedge clk);
            #1;
            modelReset();
            checkOutput();
        end
        rst = 1'b0; det_clr_i = 0; det_en_i = 1; thr_hi_i = 16'd1000;
        thr_lo_i = 16'd800; deb_i = 4'd2;
        applyStimulus(1'b0, 16'h0000);
        chk("low_after_en", {15'b0, det_o}, 16'h0000);

        $display("[TB] rise after third strobe with gaps");
        strobe(16'd1000);
        strobe(16'd1000);
        applyStimulus(1'b0, 16'h0000);
        applyStimulus(1'b1, 16'd1000);
        chk("rise_pulse", {15'b0, det_rise_o}, 16'h0001);
        chk("rise_level", {15'b0, det_o}, 16'h0001);
        applyStimulus(1'b0, 16'h0000);
        chk("rise_one_clk", {15'b0, det_rise_o}, 16'h0000);

        $display("[TB] fall with band sample ignored");
        strobe(16'd801);
        strobe(16'd800);
        strobe(16'd800);
        applyStimulus(1'b1, 16'd800);
        chk("fall_pulse", {15'b0, det_fall_o}, 16'h0001);
        chk("fall_level", {15'b0, det_o}, 16'h0000);

        $display("[TB] debounce restart");
        strobe(16'd1000);
        strobe(16'd1000);
        strobe(16'd900);
        strobe(16'd1000);
        strobe(16'd1000);
        chk("no_early_rise", {15'b0, det_o}, 16'h0000);
        applyStimulus(1'b1, 16'd1000);
        chk("late_rise", {15'b0, det_rise_o}, 16'h0001);
        strobe(16'd800);
        strobe(16'd800);
        strobe(16'd800);

        $display("[TB] config error freeze");
        thr_lo_i = 16'd1200;
        applyStimulus(1'b0, 16'h0000);
        chk("err_set", {15'b0, err_cfg_o}, 16'h0001);
        strobe(16'd2000);
        strobe(16'd2000);
        strobe(16'd2000);
        chk("err_frozen", {15'b0, det_o}, 16'h0000);
        thr_lo_i = 16'd800;
        applyStimulus(1'b0, 16'h0000);
        chk("err_clear", {15'b0, err_cfg_o}, 16'h0000);
        strobe(16'd2000);
        strobe(16'd2000);
        chk("resume_cnt0", {15'b0, det_o}, 16'h0000);
        strobe(16'd2000);
        chk("resume_rise", {15'b0, det_o}, 16'h0001);

        $display("[TB] clear while high");
        det_clr_i = 1;
        applyStimulus(1'b1, 16'h0FFF);
        chk("clr_level", {15'b0, det_o}, 16'h0000);
        chk("clr_no_fall", {15'b0, det_fall_o}, 16'h0000);
        det_clr_i = 0;
        strobe(16'h0100);
        strobe(16'h0FFF);
        strobe(16'h0200);
`ifdef STE_THR_DET_PEAK_EN
        chk("peak_hold", peak_o, 16'h0FFF);
`endif

        $display("[TB] async reset mid-operation");
        rst = 1'b1;
        #2;
        modelReset();
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 16'h0000);

        $display("[TB] randomized run");
        thr_hi_i = 16'd150; thr_lo_i = 16'd100; deb_i = 4'd1;
        for (int i = 0; i < 1500; i++) begin
            det_en_i  = ($urandom % 60) != 0;
            det_clr_i = ($urandom % 70) == 0;
            if (($urandom % 25) == 0) begin
                thr_hi_i = 16'($urandom_range(100, 200));
                thr_lo_i = 16'($urandom_range(50, 210));
            end
            if (($urandom % 20) == 0) deb_i = 4'($urandom_range(0, 3));
            applyStimulus(1'(($urandom % 3) != 0), 16'($urandom_range(0, 300)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
